// File: rtl/alu_if.sv
// Operand/result bundle between the tarhi CPU core and its ALU.
// The CPU side is the master; the ALU is the slave.
interface alu_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       op;
  logic [WIDTH-1:0] inp1;
  logic [WIDTH-1:0] inp2;
  logic [WIDTH-1:0] outp;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;

  modport master (
    output op, inp1, inp2,
    input  outp, zero, neg, carry, ovf
  );

  modport slave (
    input  op, inp1, inp2,
    output outp, zero, neg, carry, ovf
  );
endinterface

// File: rtl/alu.sv
// Eight-operation ALU for the tarhi core. The result and the flags leave through
// a single register stage, so latency is one cycle and a new operation can be accepted every cycle.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  // ---- stage p0: combinational evaluation of every operation ----
  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic        [SH_W-1:0]  sh_p0;
  logic        [WIDTH:0]   sum_p0;
  logic        [WIDTH:0]   diff_p0;
  logic        [WIDTH:0]   shl_p0;
  logic        [WIDTH:0]   shr_p0;
  logic                    sub_v_p0;
  logic                    lt_p0;
  logic        [WIDTH-1:0] res_p0;
  logic                    carry_p0;
  logic                    ovf_p0;

  assign a_p0  = bus.inp1;
  assign b_p0  = bus.inp2;
  assign sh_p0 = bus.inp2[SH_W-1:0];

  // The extra bit of each 33-bit form carries add-carry, borrow or the last bit shifted out.
  assign sum_p0  = {1'b0, a_p0} + {1'b0, b_p0};
  assign diff_p0 = {1'b0, a_p0} - {1'b0, b_p0};
  assign shl_p0  = {1'b0, a_p0} << sh_p0;
  assign shr_p0  = {a_p0, 1'b0} >> sh_p0;

  assign sub_v_p0 = sub_ovf(a_p0[WIDTH-1], b_p0[WIDTH-1], diff_p0[WIDTH-1]);
  assign lt_p0    = diff_p0[WIDTH-1] ^ sub_v_p0;

  always_comb begin
    res_p0   = '0;
    carry_p0 = 1'b0;
    ovf_p0   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        res_p0   = sum_p0[WIDTH-1:0];
        carry_p0 = sum_p0[WIDTH];
        ovf_p0   = add_ovf(a_p0[WIDTH-1], b_p0[WIDTH-1], sum_p0[WIDTH-1]);
      end
      OP_SUB: begin
        res_p0   = diff_p0[WIDTH-1:0];
        carry_p0 = diff_p0[WIDTH];
        ovf_p0   = sub_v_p0;
      end
      OP_AND: res_p0 = a_p0 & b_p0;
      OP_OR:  res_p0 = a_p0 | b_p0;
      OP_XOR: res_p0 = a_p0 ^ b_p0;
      OP_SHL: begin
        res_p0   = shl_p0[WIDTH-1:0];
        carry_p0 = shl_p0[WIDTH];
      end
      OP_SHR: begin
        res_p0   = shr_p0[WIDTH:1];
        carry_p0 = shr_p0[0];
      end
      OP_SLT: res_p0 = {{(WIDTH-1){1'b0}}, lt_p0};
      default: res_p0 = '0;
    endcase
  end

  // ---- stage p1: output register ----
  logic [WIDTH-1:0] result_p1;
  logic             zero_p1;
  logic             neg_p1;
  logic             carry_p1;
  logic             ovf_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      result_p1 <= '0;
      zero_p1   <= 1'b1;
      neg_p1    <= 1'b0;
      carry_p1  <= 1'b0;
      ovf_p1    <= 1'b0;
    end else begin
      result_p1 <= res_p0;
      zero_p1   <= (res_p0 == '0);
      neg_p1    <= res_p0[WIDTH-1];
      carry_p1  <= carry_p0;
      ovf_p1    <= ovf_p0;
    end
  end

  assign bus.outp  = result_p1;
  assign bus.zero  = zero_p1;
  assign bus.neg   = neg_p1;
  assign bus.carry = carry_p1;
  assign bus.ovf   = ovf_p1;

endmodule

// File: tb/tb_alu.sv
// Bench for the tarhi ALU: fixed vector table plus reset, hold and random sequences,
// all checked one cycle later through an expected-result queue.
module tb_alu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_if #(.WIDTH(32)) bus ();

  alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] outp;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        ovf;
  } res_t;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    res_t        exp;
  } vec_t;

  res_t  sb[$];
  string sb_name[$];
  int    checks   = 0;
  int    failures = 0;

  localparam res_t RST_VAL = '{outp: 32'd0, zero: 1'b1, neg: 1'b0, carry: 1'b0, ovf: 1'b0};

  function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic [63:0] wide;
    longint      sres;
    int          sh;
    r    = '0;
    sh   = int'(b[4:0]);
    case (op)
      3'd0: begin
        wide    = {32'd0, a} + {32'd0, b};
        r.outp  = wide[31:0];
        r.carry = wide[32];
        sres    = longint'($signed(a)) + longint'($signed(b));
        r.ovf   = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      3'd1: begin
        r.outp  = a - b;
        r.carry = (a < b);
        sres    = longint'($signed(a)) - longint'($signed(b));
        r.ovf   = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      3'd2: r.outp = a & b;
      3'd3: r.outp = a | b;
      3'd4: r.outp = a ^ b;
      3'd5: begin
        r.outp  = a << sh;
        r.carry = (sh != 0) ? a[32-sh] : 1'b0;
      end
      3'd6: begin
        r.outp  = a >> sh;
        r.carry = (sh != 0) ? a[sh-1] : 1'b0;
      end
      default: r.outp = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    r.zero = (r.outp == 32'd0);
    r.neg  = r.outp[31];
    return r;
  endfunction

  function automatic res_t mk(input logic [31:0] o, input logic z, input logic n,
                              input logic c, input logic v);
    res_t r;
    r.outp = o; r.zero = z; r.neg = n; r.carry = c; r.ovf = v;
    return r;
  endfunction

  task automatic compare(input string name, input res_t exp);
    res_t got;
    got = '{outp: bus.outp, zero: bus.zero, neg: bus.neg, carry: bus.carry, ovf: bus.ovf};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got outp=%h z=%b n=%b c=%b v=%b, want outp=%h z=%b n=%b c=%b v=%b",
               name, got.outp, got.zero, got.neg, got.carry, got.ovf,
               exp.outp, exp.zero, exp.neg, exp.carry, exp.ovf);
    end
  endtask

  // Presents inputs for one edge, then checks the entry that edge should have produced.
  task automatic step(input string name, input logic rst, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input res_t exp);
    reset    = rst;
    bus.op   = op;
    bus.inp1 = a;
    bus.inp2 = b;
    sb.push_back(exp);
    sb_name.push_back(name);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      compare(sb_name.pop_front(), sb.pop_front());
    end
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{"add_wrap",   3'd0, 32'hFFFF_FFFF, 32'h1,         mk(32'h0000_0000, 1, 0, 1, 0)},
      '{"add_ovf",    3'd0, 32'h7FFF_FFFF, 32'h1,         mk(32'h8000_0000, 0, 1, 0, 1)},
      '{"sub_3_5",    3'd1, 32'd3,         32'd5,         mk(32'hFFFF_FFFE, 0, 1, 1, 0)},
      '{"slt_3_5",    3'd7, 32'd3,         32'd5,         mk(32'h0000_0001, 0, 0, 0, 0)},
      '{"slt_min_1",  3'd7, 32'h8000_0000, 32'h1,         mk(32'h0000_0001, 0, 0, 0, 0)},
      '{"and",        3'd2, 32'hF0F0_1234, 32'h0000_0024, mk(32'h0000_0024, 0, 0, 0, 0)},
      '{"or",         3'd3, 32'hF0F0_1234, 32'h0000_0024, mk(32'hF0F0_1234, 0, 1, 0, 0)},
      '{"xor",        3'd4, 32'hF0F0_1234, 32'h0000_0024, mk(32'hF0F0_1210, 0, 1, 0, 0)},
      '{"shl4",       3'd5, 32'hF0F0_1234, 32'h0000_0024, mk(32'h0F01_2340, 0, 0, 1, 0)},
      '{"shr4",       3'd6, 32'hF0F0_1234, 32'h0000_0024, mk(32'h0F0F_0123, 0, 0, 0, 0)},
      '{"shl32_is_0", 3'd5, 32'hF0F0_1234, 32'h0000_0020, mk(32'hF0F0_1234, 0, 1, 0, 0)},
      '{"shr1_carry", 3'd6, 32'h0000_0001, 32'h0000_0001, mk(32'h0000_0000, 1, 0, 1, 0)},
      '{"shl31",      3'd5, 32'h0000_0001, 32'h0000_001F, mk(32'h8000_0000, 0, 1, 0, 0)},
      '{"sub_eq",     3'd1, 32'd5,         32'd5,         mk(32'h0000_0000, 1, 0, 0, 0)},
      '{"sub_ovf",    3'd1, 32'h8000_0000, 32'h1,         mk(32'h7FFF_FFFF, 0, 0, 0, 1)},
      '{"slt_5_3",    3'd7, 32'd5,         32'd3,         mk(32'h0000_0000, 1, 0, 0, 0)},
      '{"slt_1_min",  3'd7, 32'h1,         32'h8000_0000, mk(32'h0000_0000, 1, 0, 0, 0)}
    };

    reset    = 1'b1;
    bus.op   = 3'd0;
    bus.inp1 = 32'd5;
    bus.inp2 = 32'd7;

    // Reset held for two cycles with an ADD presented, then released.
    step("reset_1", 1'b1, 3'd0, 32'd5, 32'd7, RST_VAL);
    step("reset_2", 1'b1, 3'd0, 32'd5, 32'd7, RST_VAL);
    step("after_reset_add", 1'b0, 3'd0, 32'd5, 32'd7, mk(32'd12, 0, 0, 0, 0));

    foreach (vecs[i])
      step(vecs[i].name, 1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Back-to-back: a different opcode on every edge, no idle cycles.
    step("b2b_add", 1'b0, 3'd0, 32'd3, 32'd5, mk(32'd8,          0, 0, 0, 0));
    step("b2b_sub", 1'b0, 3'd1, 32'd3, 32'd5, mk(32'hFFFF_FFFE,  0, 1, 1, 0));
    step("b2b_and", 1'b0, 3'd2, 32'd3, 32'd5, mk(32'd1,          0, 0, 0, 0));
    step("b2b_or",  1'b0, 3'd3, 32'd3, 32'd5, mk(32'd7,          0, 0, 0, 0));
    step("b2b_xor", 1'b0, 3'd4, 32'd3, 32'd5, mk(32'd6,          0, 0, 0, 0));
    step("b2b_shl", 1'b0, 3'd5, 32'd3, 32'd5, mk(32'h60,         0, 0, 0, 0));
    step("b2b_shr", 1'b0, 3'd6, 32'd3, 32'd5, mk(32'd0,          1, 0, 0, 0));
    step("b2b_slt", 1'b0, 3'd7, 32'd3, 32'd5, mk(32'd1,          0, 0, 0, 0));

    // Inputs wiggling between edges must not disturb the held outputs.
    bus.op   = 3'd0;
    bus.inp1 = 32'h1234_5678;
    bus.inp2 = 32'h1111_1111;
    #3;
    compare("hold_between_edges", mk(32'd1, 0, 0, 0, 0));

    // Mid-stream reset drops the operation presented with it; next cycle computes normally.
    step("pre_reset_add", 1'b0, 3'd0, 32'd1, 32'd1, mk(32'd2, 0, 0, 0, 0));
    step("midstream_rst", 1'b1, 3'd0, 32'hFFFF_FFFF, 32'h1, RST_VAL);
    step("post_rst_sub",  1'b0, 3'd1, 32'd10, 32'd4, mk(32'd6, 0, 0, 0, 0));

    // Random sweep against the reference model.
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 4 == 0) ? ra : $urandom;
      step($sformatf("rand_%0d_op%0d", i, rop), 1'b0, rop, ra, rb, model(rop, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

32-bit, 8-operation arithmetic/logic unit for the `tarhi` CPU core. The CPU drives a 3-bit opcode from `instruct[29:27]` and two 32-bit operands selected from r0..r3. The ALU returns a registered 32-bit result plus status flags. The CPU writes the result back into a register.

## Interface
Parameters:
- `WIDTH`, default 32, operand/result width. Only 32 is required to be supported.

Ports:
- `clk`, input, 1, rising-edge clock.
- `reset`, input, 1. Reset is synchronous and active-high.
- `op`, input, 3, operation select.
- `inp1`, input, 32, operand A.
- `inp2`, input, 32, operand B.
- `outp`, output, 32, registered result.
- `zero`, output, 1, registered: result == 0.
- `neg`, output, 1, registered: result[31].
- `carry`, output, 1, registered carry/borrow (see Operation).
- `ovf`, output, 1, registered signed overflow.

## Operation
- Opcode map (A=`inp1`, B=`inp2`):
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND: A&B.
  - 011 OR: A|B.
  - 100 XOR: A^B.
  - 101 SHL: A << B[4:0]. Zero-fill.
  - 110 SHR: A >> B[4:0]. Logical, zero-fill.
  - 111 SLT: 32'd1 if signed(A) < signed(B), else 0.
- Arithmetic is modulo 2^32. Result is truncated to 32 bits. Wrap-around is legal and not an error.
- ADD:
  - `carry` = bit 32 of the 33-bit unsigned sum.
  - `ovf` = operands have the same sign and the result sign differs.
- SUB:
  - `carry` = borrow, 1 when A < B unsigned.
  - `ovf` = operand signs differ and the result sign differs from A.
- SLT: computed via A−B, overflow-corrected. Signed compare means `neg_of_diff XOR ovf_of_diff`.
- SHL: `carry` = last bit shifted out, i.e. A[32−sh] when sh≠0. Otherwise 0.
- SHR: `carry` = A[sh−1] when sh≠0. Otherwise 0.
- Logic ops and SLT: `carry`=0 and `ovf`=0.
- Shift amount uses only B[4:0]. B[31:5] is ignored, so a shift of 32 behaves as a shift of 0.
- `zero` and `neg` are derived from the 32-bit result for all ops.
- The block is purely datapath. It has no state machine. The only state is the output register.

## Timing
- All outputs update on the rising edge of `clk`. Latency is exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput is one operation per cycle. New op/operands may change every cycle with no handshake.
- Reset behaviour:
  - `reset`=1 at a rising edge: `outp`=0, `zero`=1, `neg`=0, `carry`=0, `ovf`=0.
  - Reset has priority over any operation presented in the same cycle.
  - Reset asserted mid-stream discards the in-flight result.
  - The first cycle after reset deasserts computes normally.
- Outputs hold their value between edges. Inputs changing between edges have no effect on outputs.
- No X propagation: every opcode value is defined.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with op=000, A=5, B=7. Required: `outp`=0, `zero`=1, other flags 0. Release reset: next cycle `outp`=12.
- ADD wrap: A=32'hFFFFFFFF, B=1, op=000. Required: `outp`=0, `zero`=1, `carry`=1, `ovf`=0.
- ADD signed overflow: A=32'h7FFFFFFF, B=1. Required: `outp`=32'h80000000, `neg`=1, `ovf`=1, `carry`=0.
- SUB/SLT: A=3, B=5.
  - op=001 gives `outp`=32'hFFFFFFFE, `carry`=1.
  - op=111 gives `outp`=1.
  - op=111 with A=32'h80000000, B=1 gives `outp`=1.
- Logic/shift sweep: A=32'hF0F0_1234, B=32'h0000_0024.
  - AND gives 32'h0000_0024 & A = 32'h0000_0024.
  - OR gives 32'hF0F0_1234.
  - XOR gives 32'hF0F0_1210.
  - SHL gives 32'h0F01_2340 (shift 4, `carry`=1).
  - SHR gives 32'h0F0F_0123 (`carry`=0).
- Back-to-back pipelining: change op every cycle through all 8 codes. Each result must appear exactly one cycle after its inputs, with no bubbles.
